// File: rtl/event_dispatch_fsm.sv
// event_dispatch_fsm: dispatches one buffered event to two DDL links and acks once all enabled links finish.
// Optional completion timeout enabled by defining EVENT_DISPATCH_TIMEOUT_EN.
module event_dispatch_fsm #(
    parameter int                TOUT_W   = 16,
    parameter logic [TOUT_W-1:0] TOUT_MAX = 16'hFFFF,
    parameter int                CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             event_rdy,
    input  logic [1:0]       ddl_xoff,
    input  logic [1:0]       ddl_done,
    input  logic             err_clr,
    output logic [1:0]       ddl_start,
    output logic             event_ack,
    output logic             busy,
    output logic             timeout_err,
    output logic [1:0]       err_link,
    output logic [CNT_W-1:0] sent_cnt
);
    typedef enum logic [2:0] {IDLE, START, WAIT, ACK, RELEASE} state_t;
    state_t state, state_n;
    logic [1:0] mask, mask_n, pend, pend_n, pend_w, start_n;
    logic [CNT_W-1:0] cnt_n;
    logic ack_n, tout;
    // links that go xoff mid-event are released along with those reporting done
    assign pend_w = pend & ~ddl_done & ~ddl_xoff;
`ifdef EVENT_DISPATCH_TIMEOUT_EN
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_MAX - 1'b1;
    logic [TOUT_W-1:0] timer;
    // completion in the same cycle as the timeout takes priority
    assign tout = (state == WAIT) && (timer == TOUT_LAST) && (pend_w != 2'b00);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer       <= '0;
            timeout_err <= 1'b0;
            err_link    <= 2'b00;
        end else begin
            timer       <= (state == START) ? '0 : (state == WAIT) ? timer + 1'b1 : timer;
            timeout_err <= tout ? 1'b1 : err_clr ? 1'b0 : timeout_err;
            err_link    <= tout ? (err_link | pend_w) : err_clr ? 2'b00 : err_link;
        end
    end
`else
    logic unused_tout;
    assign unused_tout = ^{err_clr, TOUT_MAX};
    assign tout        = 1'b0;
    assign timeout_err = 1'b0;
    assign err_link    = 2'b00;
`endif
    always_comb begin
        state_n = state;
        mask_n  = mask;
        pend_n  = pend;
        start_n = 2'b00;
        ack_n   = 1'b0;
        cnt_n   = sent_cnt;
        case (state)
            IDLE: if (event_rdy) begin
                mask_n  = ~ddl_xoff;
                state_n = (ddl_xoff != 2'b11) ? START : ACK;
            end
            START: begin
                start_n = mask;
                pend_n  = mask;
                state_n = WAIT;
            end
            WAIT: begin
                pend_n  = pend_w;
                state_n = (pend_w == 2'b00 || tout) ? ACK : WAIT;
            end
            ACK: begin
                ack_n   = 1'b1;
                cnt_n   = sent_cnt + 1'b1;
                state_n = RELEASE;
            end
            RELEASE: state_n = event_rdy ? RELEASE : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mask      <= 2'b00;
            pend      <= 2'b00;
            ddl_start <= 2'b00;
            event_ack <= 1'b0;
            busy      <= 1'b0;
            sent_cnt  <= '0;
        end else begin
            state     <= state_n;
            mask      <= mask_n;
            pend      <= pend_n;
            ddl_start <= start_n;
            event_ack <= ack_n;
            busy      <= (state_n != IDLE);
            sent_cnt  <= cnt_n;
        end
    end
endmodule

// File: tb/tb_event_dispatch_fsm.sv
// tb_event_dispatch_fsm: scoreboard bench for event_dispatch_fsm (TOUT_MAX=8, CNT_W=4).
module tb_event_dispatch_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1, event_rdy = 1'b0, err_clr = 1'b0;
    logic [1:0] ddl_xoff = 2'b00, ddl_done = 2'b00;
    logic [1:0] ddl_start, err_link;
    logic       event_ack, busy, timeout_err;
    logic [3:0] sent_cnt;
    int checks = 0, failures = 0, cnt_m = 0;
    int exp_q[$];

    event_dispatch_fsm #(.TOUT_W(16), .TOUT_MAX(16'd8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .event_rdy(event_rdy), .ddl_xoff(ddl_xoff),
        .ddl_done(ddl_done), .err_clr(err_clr), .ddl_start(ddl_start),
        .event_ack(event_ack), .busy(busy), .timeout_err(timeout_err),
        .err_link(err_link), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] xo);
        ddl_xoff = xo;
        event_rdy = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1 || ddl_start !== 2'b00) begin
            failures++;
            $display("FAIL launch_busy busy=%b start=%b required busy=1 start=00", busy, ddl_start);
        end
        step();
        checks++;
        if (ddl_start !== ~xo) begin
            failures++;
            $display("FAIL launch_start start=%b required=%b", ddl_start, ~xo);
        end
        cnt_m = (cnt_m + 1) % 16;
        exp_q.push_back(cnt_m);
    endtask

    task automatic pulse_done(input logic [1:0] d);
        ddl_done = d;
        step();
        ddl_done = 2'b00;
    endtask

    task automatic take_ack(input string nm);
        int e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (event_ack !== 1'b1 || sent_cnt !== e) begin
            failures++;
            $display("FAIL %s ack=%b cnt=%0d required ack=1 cnt=%0d", nm, event_ack, sent_cnt, e);
        end
    endtask

    task automatic release_rdy();
        event_rdy = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || event_ack !== 1'b0) begin
            failures++;
            $display("FAIL release busy=%b ack=%b required 0 0", busy, event_ack);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({ddl_start, event_ack, busy, timeout_err, err_link, sent_cnt} !== 11'd0) begin
            failures++;
            $display("FAIL reset_state outs=%b required all 0",
                     {ddl_start, event_ack, busy, timeout_err, err_link, sent_cnt});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_dual();
        launch(2'b00);
        step();
        checks++;
        if (ddl_start !== 2'b00) begin
            failures++;
            $display("FAIL dual_start_width start=%b required=00", ddl_start);
        end
        step();
        pulse_done(2'b01);
        step();
        pulse_done(2'b10);
        checks++;
        if (event_ack !== 1'b0) begin
            failures++;
            $display("FAIL dual_ack_early ack=%b required=0", event_ack);
        end
        step();
        take_ack("dual_ack");
        release_rdy();
    endtask

    task automatic test_single();
        launch(2'b01);
        pulse_done(2'b01);
        step();
        checks++;
        if (event_ack !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_ignore ack=%b busy=%b required ack=0 busy=1", event_ack, busy);
        end
        pulse_done(2'b10);
        step();
        take_ack("single_ack");
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ddl_start !== 2'b00 || event_ack !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL single_hold start=%b ack=%b busy=%b required 00 0 1", ddl_start, event_ack, busy);
            end
        end
        release_rdy();
    endtask

    task automatic test_drop();
        launch(2'b11);
        take_ack("drop_ack");
        release_rdy();
    endtask

    task automatic test_timeout();
        launch(2'b00);
        pulse_done(2'b01);
        repeat (6) step();
`ifdef EVENT_DISPATCH_TIMEOUT_EN
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL tout_early err=%b required=0", timeout_err);
        end
        step();
        checks++;
        if (timeout_err !== 1'b1 || err_link !== 2'b10 || event_ack !== 1'b0) begin
            failures++;
            $display("FAIL tout_fire err=%b link=%b ack=%b required 1 10 0", timeout_err, err_link, event_ack);
        end
        step();
        take_ack("tout_ack");
        release_rdy();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || err_link !== 2'b00) begin
            failures++;
            $display("FAIL tout_clr err=%b link=%b required 0 00", timeout_err, err_link);
        end
        launch(2'b00);
        pulse_done(2'b01);
        repeat (6) step();
        pulse_done(2'b10);
        step();
        take_ack("tout_coincide_ack");
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL tout_coincide err=%b required=0", timeout_err);
        end
        release_rdy();
`else
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (event_ack === 1'b1) seen++;
            end
            checks++;
            if (seen != 0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
                failures++;
                $display("FAIL notout_stall acks=%0d busy=%b err=%b required 0 1 0", seen, busy, timeout_err);
            end
        end
        reset = 1'b1;
        event_rdy = 1'b0;
        step();
        reset = 1'b0;
        exp_q.delete();
        cnt_m = 0;
        step();
`endif
    endtask

    task automatic test_xoff_mid();
        launch(2'b00);
        step();
        ddl_xoff = 2'b10;
        step();
        pulse_done(2'b01);
        step();
        take_ack("xoff_mid_ack");
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL xoff_mid_err err=%b required=0", timeout_err);
        end
        release_rdy();
        ddl_xoff = 2'b00;
    endtask

    task automatic test_both_done();
        launch(2'b00);
        pulse_done(2'b11);
        step();
        take_ack("both_done_ack");
        release_rdy();
    endtask

    task automatic test_reset_mid();
        launch(2'b00);
        step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ddl_start, event_ack, busy, timeout_err, err_link, sent_cnt} !== 11'd0) begin
            failures++;
            $display("FAIL reset_async outs=%b required all 0",
                     {ddl_start, event_ack, busy, timeout_err, err_link, sent_cnt});
        end
        exp_q.delete();
        cnt_m = 0;
        event_rdy = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (ddl_start !== 2'b00 || event_ack !== 1'b0 || busy !== 1'b0 || sent_cnt !== 4'd0) begin
                failures++;
                $display("FAIL reset_quiet start=%b ack=%b busy=%b cnt=%0d required 00 0 0 0",
                         ddl_start, event_ack, busy, sent_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            launch(2'b11);
            take_ack("wrap_ack");
            release_rdy();
        end
        checks++;
        if (sent_cnt !== 4'd0) begin
            failures++;
            $display("FAIL wrap_zero cnt=%0d required=0", sent_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_dual();
        test_single();
        test_drop();
        test_timeout();
        test_xoff_mid();
        test_both_done();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/event_dispatch_fsm.md
Name: event_dispatch_fsm

Overview:
Dispatches one buffered event to the two DDL link senders and returns a single acknowledge to the event builder once every enabled link reports completion. Sits between the SRU event buffer and the two DDL transmit channels. Links flagged by ddl_xoff are excluded from dispatch and from completion tracking. Includes a completion timeout so a dead link cannot stall readout.

Parameters:
TOUT_W, 16, width of the completion timeout counter
TOUT_MAX, 16'hFFFF, WAIT-state cycles before timeout fires (must be at least 1)
CNT_W, 16, width of the sent-event counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
event_rdy  input  1  level; event buffered and ready, held until event_ack
ddl_xoff  input  2  per-link disable; bit0 = link0, bit1 = link1; 1 = excluded
ddl_done  input  2  per-link single-cycle pulse; link finished sending the event
err_clr  input  1  single-cycle pulse; clears timeout_err and err_link
ddl_start  output  2  per-link single-cycle start pulse
event_ack  output  1  single-cycle pulse; event fully dispatched or dropped
busy  output  1  high in every state except IDLE
timeout_err  output  1  sticky timeout flag
err_link  output  2  pending-link mask captured at timeout; sticky
sent_cnt  output  CNT_W  number of events acknowledged; wraps to 0

Behaviour:
- Reset (async, active-high): state=IDLE; ddl_start=0, event_ack=0, busy=0, timeout_err=0, err_link=0, sent_cnt=0; internal mask, pend and timer=0. Reset mid-event aborts with no ack; no start pulse is issued after reset asserts.
- All outputs are registered.
- States: IDLE, START, WAIT, ACK, RELEASE.
- IDLE: when event_rdy=1, latch mask <= ~ddl_xoff.
  - mask != 00 -> START.
  - mask == 00 (both links xoff) -> ACK; the event is dropped and still acknowledged.
- START: ddl_start <= mask for exactly one cycle; pend <= mask; timer <= 0; -> WAIT.
- WAIT: each cycle, pend <= pend & ~ddl_done & ~ddl_xoff.
  - A link going xoff mid-event is released.
  - ddl_done on a non-pending bit is ignored.
  - Both done bits in the same cycle clear both.
  - When the next pend value is 00 -> ACK (the same cycle as the last done is sampled).
  - timer increments each cycle. If timer == TOUT_MAX-1 and next pend != 00: timeout_err <= 1, err_link <= err_link | next pend, -> ACK.
  - If the last done and the timeout coincide, completion wins: no error.
- ACK: event_ack=1 for one cycle; sent_cnt <= sent_cnt+1 (modulo 2^CNT_W, including drops and timeouts); -> RELEASE.
- RELEASE: stay until event_rdy=0, then -> IDLE. This guarantees one event per event_rdy assertion; a minimum of one RELEASE cycle is always taken.
- Latency: event_rdy high in IDLE -> ddl_start 2 cycles later. Last ddl_done -> event_ack 2 cycles later.
- err_clr clears timeout_err and err_link in any state. If err_clr coincides with a new timeout, the timeout wins.
- ddl_xoff changes outside WAIT take effect at the next IDLE latch only.

Optional Feature:
EVENT_DISPATCH_TIMEOUT_EN
- Defined: timeout logic exactly as above.
- Undefined:
  - Timer removed.
  - WAIT leaves only on pend==00.
  - timeout_err and err_link are constant 0.
  - err_clr is ignored.
  - TOUT_W and TOUT_MAX are unused.

Test Plan:
- xoff=00, event_rdy=1; done=01 at WAIT+3, done=10 at WAIT+5 -> ddl_start=11 for 1 cycle; event_ack 2 cycles after the second done; sent_cnt=1.
- xoff=01, event_rdy=1 -> ddl_start=10; done=01 ignored; done=10 -> event_ack; sent_cnt=1; event_rdy held high 4 cycles after ack -> no second ddl_start until it drops and reasserts.
- xoff=11, event_rdy=1 -> no ddl_start; event_ack 2 cycles after event_rdy; sent_cnt increments.
- TOUT_MAX=8, xoff=00, only done=01 returned -> after 8 WAIT cycles timeout_err=1, err_link=10, event_ack pulses; err_clr -> both 0. Under EVENT_DISPATCH_TIMEOUT_EN undefined: FSM stays in WAIT, busy=1, no ack.
- Mid-WAIT with pend=11: set xoff=10, then done=01 -> event_ack with no error; done=11 in a single cycle -> immediate completion.
- Assert reset during WAIT -> all outputs 0 asynchronously; after release no ack or start until a fresh event_rdy; sent_cnt=0. Separately, CNT_W=4 with 16 events -> sent_cnt wraps to 0.
